// File: rtl/trng_byte_collector.sv
// Raw random bit collector: assembles WIDTH-bit words and runs a sticky repetition-count
// health test. Define TRNG_VON_NEUMANN_EN to debias the raw stream with pairwise extraction.
module trng_byte_collector #(
   parameter int WIDTH     = 8,
   parameter int REP_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enabled,
   input  logic             rnd_bit,
   output logic [WIDTH-1:0] rnd_data,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             health_fail
);
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [7:0]       REP_LIM  = 8'(REP_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2,
      ST_FAIL    = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-2:0] r_sh, w_sh_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [7:0]       r_rep, w_rep_nxt, w_rep_inc;
   logic             r_prev, w_prev_nxt;
   logic [WIDTH-1:0] r_data, w_data_nxt, w_word;
   logic             r_valid, w_valid_nxt;
   logic             r_fail, w_fail_nxt;
   logic             w_trip, w_accept, w_acc_bit, w_last;

`ifdef TRNG_VON_NEUMANN_EN
   logic r_pend, w_pend_nxt, r_first, w_first_nxt;
   // A pair of differing raw bits yields its first bit; equal pairs yield nothing.
   assign w_accept  = r_pend && (r_first != rnd_bit);
   assign w_acc_bit = r_first;
`else
   assign w_accept  = 1'b1;
   assign w_acc_bit = rnd_bit;
`endif

   assign w_rep_inc = (rnd_bit != r_prev) ? 8'd1 :
                      (r_rep == 8'hFF)    ? r_rep : r_rep + 8'd1;
   assign w_trip    = (w_rep_inc == REP_LIM);
   assign w_word    = {r_sh, w_acc_bit};
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_last    = (w_cnt_inc == CNT_LAST);

   assign rnd_data    = r_data;
   assign rnd_valid   = r_valid;
   assign health_fail = r_fail;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a health trip outranks word completion and handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enabled) w_state_nxt = ST_COLLECT;
            else         w_state_nxt = ST_IDLE;
         end
         ST_COLLECT: begin
            if (!enabled)              w_state_nxt = ST_IDLE;
            else if (w_trip)           w_state_nxt = ST_FAIL;
            else if (w_accept && w_last) w_state_nxt = ST_HOLD;
            else                       w_state_nxt = ST_COLLECT;
         end
         ST_HOLD: begin
            if (enabled && w_trip) w_state_nxt = ST_FAIL;
            else if (rnd_ready)    w_state_nxt = enabled ? ST_COLLECT : ST_IDLE;
            else                   w_state_nxt = ST_HOLD;
         end
         ST_FAIL: w_state_nxt = ST_FAIL;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      w_sh_nxt    = r_sh;
      w_cnt_nxt   = r_cnt;
      w_rep_nxt   = r_rep;
      w_prev_nxt  = r_prev;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_fail_nxt  = r_fail;
`ifdef TRNG_VON_NEUMANN_EN
      w_pend_nxt  = r_pend;
      w_first_nxt = r_first;
`endif
      case (r_state)
         ST_IDLE: begin
            if (enabled) begin
               w_rep_nxt  = 8'd1;
               w_prev_nxt = rnd_bit;
`ifdef TRNG_VON_NEUMANN_EN
               w_pend_nxt  = 1'b1;
               w_first_nxt = rnd_bit;
`else
               w_sh_nxt  = w_word[WIDTH-2:0];
               w_cnt_nxt = CNT_W'(1);
`endif
            end else begin
               w_cnt_nxt = '0;
            end
         end
         ST_COLLECT: begin
            if (!enabled) begin
               w_cnt_nxt = '0;
               w_rep_nxt = 8'd0;
`ifdef TRNG_VON_NEUMANN_EN
               w_pend_nxt = 1'b0;
`endif
            end else begin
               w_rep_nxt  = w_rep_inc;
               w_prev_nxt = rnd_bit;
               if (w_trip) begin
                  w_fail_nxt  = 1'b1;
                  w_valid_nxt = 1'b0;
               end else begin
`ifdef TRNG_VON_NEUMANN_EN
                  w_pend_nxt  = !r_pend;
                  w_first_nxt = rnd_bit;
`endif
                  if (w_accept) begin
                     w_sh_nxt = w_word[WIDTH-2:0];
                     if (w_last) begin
                        w_data_nxt  = w_word;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                     end else begin
                        w_cnt_nxt = w_cnt_inc;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (enabled) begin
               w_rep_nxt  = w_rep_inc;
               w_prev_nxt = rnd_bit;
            end else begin
               w_rep_nxt = r_rep;
            end
            if (enabled && w_trip) begin
               w_fail_nxt  = 1'b1;
               w_valid_nxt = 1'b0;
            end else if (rnd_ready) begin
               w_valid_nxt = 1'b0;
               if (!enabled) w_rep_nxt = 8'd0;
               else          w_rep_nxt = w_rep_inc;
            end else begin
               w_valid_nxt = r_valid;
            end
         end
         ST_FAIL: begin
            w_valid_nxt = 1'b0;
            w_fail_nxt  = 1'b1;
         end
         default: begin
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh    <= '0;
         r_cnt   <= '0;
         r_rep   <= 8'd0;
         r_prev  <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_fail  <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
         r_pend  <= 1'b0;
         r_first <= 1'b0;
`endif
      end else begin
         r_sh    <= w_sh_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rep   <= w_rep_nxt;
         r_prev  <= w_prev_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_fail  <= w_fail_nxt;
`ifdef TRNG_VON_NEUMANN_EN
         r_pend  <= w_pend_nxt;
         r_first <= w_first_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_trng_byte_collector.sv
// Self-checking bench for trng_byte_collector: directed steps plus randomized traffic
// against a queue-based reference model; honours TRNG_VON_NEUMANN_EN.
module tb_trng_byte_collector;
   localparam int LP_W   = 8;
   localparam int LP_REP = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            enabled, rnd_bit, rnd_ready;
   logic [LP_W-1:0] rnd_data;
   logic            rnd_valid, health_fail;
   logic            en8, bit8, rdy8;
   logic [LP_W-1:0] data8;
   logic            valid8, fail8;

   int n_cmp;
   int n_bad;

   // Reference model state
   logic            m_fail, m_active, m_hold, m_valid;
   logic [LP_W-1:0] m_data;
   int              m_run;
   logic            m_prev, m_pend, m_first;
   logic            q_bits[$];

   trng_byte_collector #(.WIDTH(LP_W), .REP_LIMIT(LP_REP)) dut (
      .clk(clk), .rst_n(rst_n), .enabled(enabled), .rnd_bit(rnd_bit),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .health_fail(health_fail));

   trng_byte_collector #(.WIDTH(LP_W), .REP_LIMIT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .enabled(en8), .rnd_bit(bit8),
      .rnd_data(data8), .rnd_valid(valid8), .rnd_ready(rdy8),
      .health_fail(fail8));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fail = 1'b0; m_active = 1'b0; m_hold = 1'b0; m_valid = 1'b0;
      m_data = '0; m_run = 0; m_prev = 1'b0; m_pend = 1'b0; m_first = 1'b0;
      q_bits.delete();
   endtask

   function automatic logic [LP_W-1:0] pack_bits();
      logic [LP_W-1:0] w;
      w = '0;
      foreach (q_bits[i]) w = {w[LP_W-2:0], q_bits[i]};
      return w;
   endfunction

   task automatic accept_raw(input logic b);
`ifdef TRNG_VON_NEUMANN_EN
      if (!m_pend) begin
         m_pend = 1'b1; m_first = b;
      end else begin
         m_pend = 1'b0;
         if (m_first != b) q_bits.push_back(m_first);
      end
`else
      q_bits.push_back(b);
`endif
   endtask

   task automatic health(input logic b);
      if (b == m_prev) m_run = (m_run < 255) ? m_run + 1 : m_run;
      else             m_run = 1;
      m_prev = b;
   endtask

   task automatic model_step(input logic en, input logic b, input logic rdy);
      bit tripped;
      tripped = 1'b0;
      if (m_fail) return;
      if (!m_active) begin
         if (en) begin
            m_active = 1'b1; m_run = 1; m_prev = b;
            q_bits.delete(); m_pend = 1'b0;
            accept_raw(b);
         end
      end else if (!m_hold) begin
         if (!en) begin
            m_active = 1'b0; q_bits.delete(); m_pend = 1'b0; m_run = 0;
         end else begin
            health(b);
            if (m_run == LP_REP) begin
               m_fail = 1'b1; m_valid = 1'b0;
            end else begin
               accept_raw(b);
               if (q_bits.size() == LP_W) begin
                  m_data = pack_bits(); m_valid = 1'b1; m_hold = 1'b1;
                  q_bits.delete(); m_pend = 1'b0;
               end
            end
         end
      end else begin
         if (en) begin
            health(b);
            if (m_run == LP_REP) begin
               m_fail = 1'b1; m_valid = 1'b0; m_hold = 1'b0; tripped = 1'b1;
            end
         end
         if (!tripped && rdy) begin
            m_valid = 1'b0; m_hold = 1'b0; m_active = en;
            if (!en) m_run = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("data",  32'(rnd_data),    32'(m_data));
      chk("valid", 32'(rnd_valid),   32'(m_valid));
      chk("fail",  32'(health_fail), 32'(m_fail));
   endtask

   // One clock: drive at negedge, model at posedge, check at the next negedge
   task automatic cyc(input logic en, input logic b, input logic rdy);
      enabled = en; rnd_bit = b; rnd_ready = rdy;
      @(posedge clk);
      model_step(en, b, rdy);
      @(negedge clk);
      check_all();
   endtask

   task automatic reset_pulse(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_data"},  32'(rnd_data),    32'h0);
      chk({tag, "_valid"}, 32'(rnd_valid),   32'h0);
      chk({tag, "_fail"},  32'(health_fail), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0]  basic_v;
      logic [7:0]  alt_v;
      logic [19:0] pair_v;
      logic        last_b, en_v, b_v, rdy_v;
      int          rep_pct[3];

      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; enabled = 1'b0; rnd_bit = 1'b0; rnd_ready = 1'b0;
      en8 = 1'b0; bit8 = 1'b0; rdy8 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();

      // Reset mid-word
      repeat (5) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      reset_pulse("async_rst");

      // Basic word, held while not ready, then released
      basic_v = 8'hB2;
      for (int i = 7; i >= 0; i--) cyc(1'b1, basic_v[i], 1'b0);
`ifndef TRNG_VON_NEUMANN_EN
      chk("basic_data",  32'(rnd_data),  32'hB2);
      chk("basic_valid", 32'(rnd_valid), 32'h1);
`endif
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'(i % 2), 1'b0);
`ifndef TRNG_VON_NEUMANN_EN
         chk("hold_data", 32'(rnd_data), 32'hB2);
`endif
      end
      cyc(1'b1, 1'b0, 1'b1);
      chk("ack_valid", 32'(rnd_valid), 32'h0);

      // Partial word discarded by enable drop
      repeat (5) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      repeat (2) cyc(1'b0, 1'b1, 1'b0);
      alt_v = 8'h55;
      for (int i = 7; i >= 0; i--) cyc(1'b1, alt_v[i], 1'b0);
`ifndef TRNG_VON_NEUMANN_EN
      chk("partial_data",  32'(rnd_data),  32'h55);
      chk("partial_valid", 32'(rnd_valid), 32'h1);
`endif
      reset_pulse("rst2");

      // Health threshold: 15 is tolerated, 16 trips
      repeat (8) cyc(1'b1, 1'b1, 1'b0);
`ifndef TRNG_VON_NEUMANN_EN
      chk("ones_data",  32'(rnd_data),  32'hFF);
      chk("ones_valid", 32'(rnd_valid), 32'h1);
`endif
      repeat (7) cyc(1'b1, 1'b1, 1'b0);
      chk("run15_fail", 32'(health_fail), 32'h0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (15) cyc(1'b1, 1'b1, 1'b0);
      chk("run15b_fail", 32'(health_fail), 32'h0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("run16_fail",  32'(health_fail), 32'h1);
      chk("run16_valid", 32'(rnd_valid),   32'h0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("sticky_fail",  32'(health_fail), 32'h1);
      chk("sticky_valid", 32'(rnd_valid),   32'h0);
      reset_pulse("rst3");

      // Pair-extraction pattern 01,10,00,11,01,01,10,10,01,10
      pair_v = 20'h635A6;
      for (int i = 19; i >= 0; i--) cyc(1'b1, pair_v[i], 1'b1);
`ifdef TRNG_VON_NEUMANN_EN
      chk("vn_data",  32'(rnd_data),  32'h4D);
      chk("vn_valid", 32'(rnd_valid), 32'h1);
`endif

      // Coincidence of word completion and health trip (REP_LIMIT = 8)
      en8 = 1'b1; bit8 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         chk("coin_valid", 32'(valid8), 32'h0);
         if (i == 7) chk("coin_fail7", 32'(fail8), 32'h0);
      end
      chk("coin_fail", 32'(fail8), 32'h1);
      chk("coin_data", 32'(data8), 32'h0);
      en8 = 1'b0; bit8 = 1'b0;

      // Randomized traffic with increasing run-length bias
      rep_pct[0] = 50; rep_pct[1] = 80; rep_pct[2] = 95;
      last_b = 1'b0;
      for (int r = 0; r < 3; r++) begin
         reset_pulse("rst_rand");
         for (int i = 0; i < 400; i++) begin
            en_v  = ($urandom_range(0, 9) != 0);
            b_v   = ($urandom_range(0, 99) < rep_pct[r]) ? last_b : ~last_b;
            rdy_v = 1'($urandom_range(0, 1));
            last_b = b_v;
            cyc(en_v, b_v, rdy_v);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
